// File: rtl/lcs_serial_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and a helper that sizes the slice counter.
package lcs_serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width for ndig slices, never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    if (ndig > 1) begin
      return $clog2(ndig);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/lcs_serial_sub_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
// The master side produces operands and consumes results; the slave is the subtractor.
interface lcs_serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             B_1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             BO;

  modport master (
    output in_valid, A_in, B_in, B_1, out_ready,
    input  in_ready, out_valid, S, BO
  );

  modport slave (
    input  in_valid, A_in, B_in, B_1, out_ready,
    output in_ready, out_valid, S, BO
  );
endinterface

// File: rtl/lcs_serial_sub_bg_gen.sv
// Per-bit borrow generate/propagate: a bit generates a borrow when a=0,b=1
// and passes an incoming borrow through when a==b.
module bg_gen (
  input  logic a,
  input  logic b,
  output logic g,
  output logic p
);
  assign g = ~a & b;
  assign p = ~(a ^ b);
endmodule

// File: rtl/lcs_serial_sub.sv
// Digit-serial subtractor: D = A - B - Bin (mod 2^WIDTH) with borrow-out,
// one DIGIT-bit slice per cycle LSB-first, result held until accepted.
module lcs_serial_sub
  import lcs_serial_sub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIGIT = 2
) (
  input logic           clk,
  input logic           rst_n,
  lcs_serial_sub_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("lcs_serial_sub: WIDTH must be a multiple of DIGIT");
  end

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic             borrow_r;
  logic             bo_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [DIGIT-1:0] g_s;
  logic [DIGIT-1:0] p_s;
  logic [DIGIT-1:0] d_s;
  logic             bor_out_s;
  logic [WIDTH-1:0] s_shift_s;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bg
    bg_gen u_bg (
      .a (a_r[gi]),
      .b (b_r[gi]),
      .g (g_s[gi]),
      .p (p_s[gi])
    );
  end

  // Borrow chain across the current slice and the shifted difference word.
  always_comb begin
    logic bor_v;
    d_s   = '0;
    bor_v = borrow_r;
    for (int i = 0; i < DIGIT; i++) begin
      d_s[i] = ~p_s[i] ^ bor_v;
      bor_v  = g_s[i] | (p_s[i] & bor_v);
    end
    bor_out_s = bor_v;
    // New digits enter from the MSB side so the LSB slice ends up at bit 0.
    s_shift_s = (s_r >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
  end

  // Next-state selection for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CW'(NDIG - 1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand shift registers, result and handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      s_r         <= '0;
      borrow_r    <= 1'b0;
      bo_r        <= 1'b0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r      <= bus.A_in;
            b_r      <= bus.B_in;
            borrow_r <= bus.B_1;
            cnt_r    <= '0;
          end
        end
        ST_RUN: begin
          s_r      <= s_shift_s;
          borrow_r <= bor_out_s;
          bo_r     <= bor_out_s;
          a_r      <= a_r >> DIGIT;
          b_r      <= b_r >> DIGIT;
          cnt_r    <= cnt_r + CW'(1);
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.S         = s_r;
  assign bus.BO        = bo_r;

endmodule
